// File: rtl/fetch_controller_if.sv
// Handshake and memory bus between the fetch controller and the datapath/instruction memory.
// master is the controller side; slave is the datapath/memory side.
interface fetch_controller_if;
    logic        Start;
    logic        Halt;
    logic [31:0] IMemAddress;
    logic [31:0] IMemInstruction;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic [1:0]  BufCount;
    logic        Running;

    modport master (
        input  Start, Halt, IMemInstruction, Redirect, RedirectTarget, InstrReady,
        output IMemAddress, InstrValid, Instruction, PCPlus4, BufCount, Running
    );

    modport slave (
        output Start, Halt, IMemInstruction, Redirect, RedirectTarget, InstrReady,
        input  IMemAddress, InstrValid, Instruction, PCPlus4, BufCount, Running
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fills a 2-entry fetch buffer from a
// combinational instruction memory and presents words to decode over valid/ready.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              Clk,
    input  logic              Reset,
    fetch_controller_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr [2];
    logic [31:0] r_buf_pc4   [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic [31:0] r_instr_out;
    logic [31:0] r_pc4_out;

    logic        w_pop;
    logic        w_push;
    logic        w_redirect;
    logic        w_tail;
    logic        w_head_nxt;
    logic [1:0]  w_count_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_head_instr_nxt;
    logic [31:0] w_head_pc4_nxt;
    logic        w_unused_tgt;

    assign w_unused_tgt = &{1'b0, bus.RedirectTarget[1:0]};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt wins over Start; Halt in IDLE is ignored.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.Start) w_state_nxt = S_FETCH;
            S_FETCH:  if (bus.Halt) w_state_nxt = S_HALTED;
            S_HALTED: if (bus.Start && !bus.Halt) w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        w_pop      = (r_count != 2'd0) && bus.InstrReady;
        w_redirect = bus.Redirect && (r_state != S_IDLE);
        w_push     = (r_state == S_FETCH) && !w_redirect
                     && ((r_count != 2'd2) || w_pop);
        // With two entries the tail slot is the head slot being popped.
        w_tail     = r_head ^ r_count[0];
        w_head_nxt = r_head ^ w_pop;

        w_count_nxt = r_count;
        if (w_redirect) begin
            w_count_nxt = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end

        // Forward the word being written when it lands in the new head slot.
        if (w_push && (w_tail == w_head_nxt)) begin
            w_head_instr_nxt = bus.IMemInstruction;
            w_head_pc4_nxt   = w_pc_plus4;
        end else begin
            w_head_instr_nxt = r_buf_instr[w_head_nxt];
            w_head_pc4_nxt   = r_buf_pc4[w_head_nxt];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc    <= RESET_PC;
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            if (bus.Redirect) begin
                r_pc <= {bus.RedirectTarget[31:2], 2'b00};
            end else if (w_push) begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc4[i]   <= '0;
            end
        end else if (w_push) begin
            r_buf_instr[w_tail] <= bus.IMemInstruction;
            r_buf_pc4[w_tail]   <= w_pc_plus4;
        end
    end

    // Output registers hold the last presented word once the buffer empties.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_instr_out <= '0;
            r_pc4_out   <= '0;
        end else if (!w_redirect && (w_count_nxt != 2'd0)) begin
            r_instr_out <= w_head_instr_nxt;
            r_pc4_out   <= w_head_pc4_nxt;
        end
    end

    assign bus.IMemAddress = r_pc;
    assign bus.InstrValid  = (r_count != 2'd0);
    assign bus.Instruction = r_instr_out;
    assign bus.PCPlus4     = r_pc4_out;
    assign bus.BufCount    = r_count;
    assign bus.Running     = (r_state == S_FETCH);

endmodule
